// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared constants and state encoding for the pulse symbol front end
package pulse_pkg;

  localparam int CLK_F           = 25_000_000;
  localparam int TICK_RATE       = 9600;
  localparam int TW              = 15;
  localparam int MIN_TICKS_DEF   = TICK_RATE / 100;
  localparam int SHORT_MAX_DEF   = TICK_RATE / 4;
  localparam int GAP_CYCLES_DEF  = CLK_F / 2;
  localparam int MAX_SYMBOLS_DEF = 5;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MEASURE = 3'd1;
  localparam logic [2:0] S_STOP    = 3'd2;
  localparam logic [2:0] S_SAMPLE  = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_MEASURE = S_MEASURE,
    ST_STOP    = S_STOP,
    ST_SAMPLE  = S_SAMPLE,
    ST_GAP     = S_GAP
  } state_t;

endpackage

// File: rtl/pulse_gap_timer.sv
// rtl/pulse_gap_timer.sv - inter-symbol silence counter with clear/enable/done
module pulse_gap_timer #(
  parameter int GAP_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = enable && (cnt == CW'(GAP_CYCLES - 1));

endmodule

// File: rtl/pulse_symbol_ctrl.sv
// rtl/pulse_symbol_ctrl.sv - sequences the tick counter, classifies pulses and assembles symbol words
module pulse_symbol_ctrl import pulse_pkg::*; #(
  parameter int TW          = pulse_pkg::TW,
  parameter int MIN_TICKS   = MIN_TICKS_DEF,
  parameter int SHORT_MAX   = SHORT_MAX_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int MAX_SYMBOLS = MAX_SYMBOLS_DEF,
  parameter int LW          = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pulse_in,
  output logic                   meas_start,
  input  logic [TW-1:0]          tick_total,
  output logic                   sym_valid,
  output logic [MAX_SYMBOLS-1:0] sym_bits,
  output logic [LW-1:0]          sym_len,
  output logic                   sym_ovf,
  output logic                   busy
);

  localparam logic [TW-1:0] MIN_T   = TW'(MIN_TICKS);
  localparam logic [TW-1:0] SHORT_T = TW'(SHORT_MAX);
  localparam logic [LW-1:0] CAP     = LW'(MAX_SYMBOLS);

  state_t                 state;
  logic [MAX_SYMBOLS-1:0] elem_q;
  logic [LW-1:0]          len_q;
  logic                   ovf_q;
  logic                   gap_done;

  // Timer only runs while in GAP; any other state holds it at zero.
  pulse_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state != ST_GAP),
    .enable  (state == ST_GAP),
    .done    (gap_done)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      meas_start <= 1'b0;
      elem_q     <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      sym_valid  <= 1'b0;
      sym_bits   <= '0;
      sym_len    <= '0;
      sym_ovf    <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pulse_in) begin
            state      <= ST_MEASURE;
            meas_start <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (!pulse_in) begin
            state      <= ST_STOP;
            meas_start <= 1'b0;
          end
        end
        ST_STOP: state <= ST_SAMPLE;
        ST_SAMPLE: begin
          if (tick_total < MIN_T) begin
            state <= (len_q == '0) ? ST_IDLE : ST_GAP;
          end else begin
            if (len_q < CAP) begin
              elem_q[len_q] <= (tick_total > SHORT_T);
              len_q         <= len_q + 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          // A new press wins over a timeout landing in the same cycle.
          if (pulse_in) begin
            state      <= ST_MEASURE;
            meas_start <= 1'b1;
          end else if (gap_done) begin
            sym_bits  <= elem_q;
            sym_len   <= len_q;
            sym_ovf   <= ovf_q;
            sym_valid <= 1'b1;
            elem_q    <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pulse_symbol_ctrl.md
# pulse_symbol_ctrl

Controller that sequences the shared pulse-duration tick counter for the long/short pulse front end. It starts and stops the counter around each high pulse on a synchronized input and samples the one-cycle-valid result. It classifies each pulse as short, long or glitch, and assembles up to MAX_SYMBOLS elements into a symbol word. The symbol word is closed by an inter-symbol silence timeout. It sits between the input synchronizer/debouncer and the symbol decoder.

## Interface
- TW, 15: width of the counter's tick_total.
- MIN_TICKS, 96: pulses with ticks < MIN_TICKS are glitches (10 ms at 9600 ticks/s).
- SHORT_MAX, 2400: ticks ≤ SHORT_MAX → short (0), otherwise long (1).
- GAP_CYCLES, 12_500_000: low-time clock cycles closing a symbol (0.5 s at 25 MHz).
- MAX_SYMBOLS, 5: element capacity.
- clk  in  1  system clock, 25 MHz.
- reset_n  in  1  one clock; reset is asynchronous and active-low. Top drives the counter's active-high reset from ~reset_n.
- pulse_in  in  1  already synchronized/debounced level; high = pressed.
- meas_start  out  1  registered start to the tick counter; reset 0.
- tick_total  in  TW  counter result; valid only the cycle after meas_start falls.
- sym_valid  out  1  one-cycle strobe; reset 0.
- sym_bits  out  MAX_SYMBOLS  element i at bit i (first element bit 0), 1 = long; unused bits 0; reset 0.
- sym_len  out  $clog2(MAX_SYMBOLS+1)  element count; reset 0.
- sym_ovf  out  1  more than MAX_SYMBOLS valid elements received; reset 0.
- busy  out  1  state ≠ IDLE; reset 0.

## Operation
- States: IDLE, MEASURE, STOP, SAMPLE, GAP.
- IDLE: pulse_in=1 → MEASURE, meas_start←1.
- MEASURE: pulse_in=0 → STOP, meas_start←0.
- STOP: unconditional → SAMPLE (counter latches the result this edge).
- SAMPLE: tick_total compared unsigned at full TW width.
  - ticks < MIN_TICKS: glitch, no change; → IDLE if len=0, else GAP.
  - Otherwise: bit = (ticks > SHORT_MAX).
  - len < MAX_SYMBOLS: buf[len]←bit, len++.
  - len = MAX_SYMBOLS: bit dropped, ovf←1.
  - → GAP with gap_cnt←0.
- GAP: gap_cnt increments each cycle.
  - pulse_in=1 → MEASURE, meas_start←1, gap_cnt cleared. This has priority over a timeout in the same cycle.
  - gap_cnt = GAP_CYCLES-1 → emit: sym_bits/sym_len/sym_ovf←buf/len/ovf, sym_valid←1; buf, len and ovf cleared; → IDLE.
- pulse_in high during STOP/SAMPLE is not lost: the level is re-checked in GAP/IDLE.
- sym_* outputs hold their value until the next emit.
- A press long enough to wrap the TW-bit counter (≥32768 ticks ≈ 3.41 s) is classified on the wrapped value; no saturation is applied.
- Reset mid-operation: all state, buf, counters and outputs go to 0/IDLE immediately; a partial symbol is discarded and nothing is emitted.

## Timing
- meas_start rises on the edge after pulse_in is first seen high in IDLE/GAP (1-cycle latency) and falls on the edge after pulse_in is seen low in MEASURE.
- tick_total is sampled on the 2nd edge after meas_start falls (STOP, then SAMPLE).
- Minimum cycles between release and the next MEASURE is 3; a faster re-press merges into the following measurement.
- sym_valid is high exactly one cycle, GAP_CYCLES cycles after entering GAP from the last SAMPLE.

## Structure
- Shared package pulse_pkg:
  - state encoding localparams;
  - CLK_F=25_000_000 and TICK_RATE=9600;
  - default MIN_TICKS/SHORT_MAX/GAP_CYCLES derived from them;
  - TW.
- One sub-module, pulse_gap_timer: clear/enable/done counter of width $clog2(GAP_CYCLES).
- FSM, classifier and symbol buffer stay in the top module.

## Test plan
- Bench uses a behavioural counter model returning a chosen tick_total for one cycle after meas_start falls; GAP_CYCLES=50 in simulation.
- One press with ticks=1000, then silence → after 50 cycles: sym_valid=1 for one cycle, sym_len=1, sym_bits=00000, ovf=0.
- Presses with ticks 3000, 500, 3000 → sym_len=3, sym_bits=00101.
- Six presses, all ticks=3000 → sym_len=5, sym_bits=11111, sym_ovf=1.
- Glitch ticks=50 alone → no sym_valid, returns to IDLE, busy=0. Glitch ticks=95 between two shorts → sym_len=2.
- Re-press at gap_cnt=49, same cycle as the timeout → no emit, meas_start=1 next cycle. Boundary values ticks=2400 → 0 and 2401 → 1.
- reset_n low during MEASURE with two elements buffered → meas_start=0, busy=0, and no sym_valid afterwards.
